// File: rtl/univ_shift_reg.sv
// Universal shift register with single-step and counted burst operation.
// Supports hold, shift left/right, arithmetic shift right, rotate left/right
// and parallel load, plus a busy/done handshake for bursts of N steps.
module univ_shift_reg #(
   parameter int unsigned      WIDTH     = 8,
   parameter logic [WIDTH-1:0] RESET_VAL = '0,
   localparam int unsigned     CNT_W     = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic [2:0]       mode_i,
   input  logic             en_i,
   input  logic             x_i,
   input  logic [WIDTH-1:0] load_i,
   input  logic             burst_i,
   input  logic [CNT_W-1:0] burst_len_i,
   output logic [WIDTH-1:0] sr_o,
   output logic             so_o,
   output logic             busy_o,
   output logic             done_o
);

   localparam logic [2:0] M_HOLD = 3'b000;
   localparam logic [2:0] M_SHL  = 3'b001;
   localparam logic [2:0] M_SHR  = 3'b010;
   localparam logic [2:0] M_ROL  = 3'b011;
   localparam logic [2:0] M_ROR  = 3'b100;
   localparam logic [2:0] M_LOAD = 3'b101;
   localparam logic [2:0] M_ASR  = 3'b110;

   typedef enum logic {
      S_IDLE  = 1'b0,
      S_BURST = 1'b1
   } state_e;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       mode_q, mode_d;
   logic [WIDTH-1:0] sr_q, sr_d;
   logic             so_q, so_d;
   logic             done_q, done_d;
   logic [CNT_W-1:0] len_sat;

   // Only shift/rotate modes are meaningful as burst operations.
   function automatic logic is_shift_mode(input logic [2:0] mode);
      return (mode == M_SHL) || (mode == M_SHR) || (mode == M_ROL) ||
             (mode == M_ROR) || (mode == M_ASR);
   endfunction

   // Returns {so_next, sr_next}; so is left untouched by hold and load.
   function automatic logic [WIDTH:0] apply_op(input logic [2:0]       mode,
                                               input logic [WIDTH-1:0] sr,
                                               input logic             x,
                                               input logic [WIDTH-1:0] ld,
                                               input logic             so);
      logic [WIDTH:0] res;
      case (mode)
         M_SHL:   res = {sr[WIDTH-1], sr[WIDTH-2:0], x};
         M_SHR:   res = {sr[0], x, sr[WIDTH-1:1]};
         M_ROL:   res = {sr[WIDTH-1], sr[WIDTH-2:0], sr[WIDTH-1]};
         M_ROR:   res = {sr[0], sr[0], sr[WIDTH-1:1]};
         M_ASR:   res = {sr[0], sr[WIDTH-1], sr[WIDTH-1:1]};
         M_LOAD:  res = {so, ld};
         default: res = {so, sr};
      endcase
      return res;
   endfunction

   // Burst length requests beyond the register width clamp to WIDTH steps.
   always_comb begin
      len_sat = burst_len_i;
      if (burst_len_i > CNT_W'(WIDTH)) begin
         len_sat = CNT_W'(WIDTH);
      end
   end

   // Next-state logic: single steps and burst acceptance in IDLE, counted steps in BURST.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      mode_d  = mode_q;
      sr_d    = sr_q;
      so_d    = so_q;
      done_d  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (burst_i) begin
               // Non-shift modes with burst_i are dropped, and they still mask en_i.
               if (is_shift_mode(mode_i)) begin
                  mode_d = mode_i;
                  cnt_d  = len_sat;
                  if (len_sat == '0) begin
                     done_d = 1'b1;
                  end else begin
                     state_d = S_BURST;
                  end
               end
            end else if (en_i) begin
               {so_d, sr_d} = apply_op(mode_i, sr_q, x_i, load_i, so_q);
            end
         end
         S_BURST: begin
            {so_d, sr_d} = apply_op(mode_q, sr_q, x_i, load_i, so_q);
            cnt_d        = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
               state_d = S_IDLE;
               done_d  = 1'b1;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State register with synchronous active-low reset; reset mid-burst aborts without done.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         mode_q  <= M_HOLD;
         sr_q    <= RESET_VAL;
         so_q    <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         mode_q  <= mode_d;
         sr_q    <= sr_d;
         so_q    <= so_d;
         done_q  <= done_d;
      end
   end

   assign sr_o   = sr_q;
   assign so_o   = so_q;
   assign busy_o = (state_q == S_BURST);
   assign done_o = done_q;

endmodule

// File: tb/tb_univ_shift_reg.sv
// Scoreboard bench for univ_shift_reg (WIDTH=8, RESET_VAL=0).
module tb_univ_shift_reg;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rstn;
   logic [2:0]   mode_i;
   logic         en_i;
   logic         x_i;
   logic [W-1:0] load_i;
   logic         burst_i;
   logic [3:0]   burst_len_i;
   logic [W-1:0] sr_o;
   logic         so_o;
   logic         busy_o;
   logic         done_o;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [W-1:0] sr;
      logic         so;
      logic         busy;
      logic         done;
   } exp_t;

   exp_t exp_q[$];

   // reference model state
   logic [W-1:0] m_sr = '0;
   logic         m_so = 1'b0;
   logic         m_busy = 1'b0;
   logic         m_done = 1'b0;
   int           m_cnt = 0;
   logic [2:0]   m_mode = 3'b000;

   univ_shift_reg #(.WIDTH(W), .RESET_VAL(8'h00)) dut (
      .clk         (clk),
      .rstn        (rstn),
      .mode_i      (mode_i),
      .en_i        (en_i),
      .x_i         (x_i),
      .load_i      (load_i),
      .burst_i     (burst_i),
      .burst_len_i (burst_len_i),
      .sr_o        (sr_o),
      .so_o        (so_o),
      .busy_o      (busy_o),
      .done_o      (done_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_op(input logic [2:0] md);
      case (md)
         3'd1: begin m_so = m_sr[7]; m_sr = {m_sr[6:0], x_i}; end
         3'd2: begin m_so = m_sr[0]; m_sr = {x_i, m_sr[7:1]}; end
         3'd3: begin m_so = m_sr[7]; m_sr = {m_sr[6:0], m_sr[7]}; end
         3'd4: begin m_so = m_sr[0]; m_sr = {m_sr[0], m_sr[7:1]}; end
         3'd5: m_sr = load_i;
         3'd6: begin m_so = m_sr[0]; m_sr = {m_sr[7], m_sr[7:1]}; end
         default: ;
      endcase
   endtask

   task automatic model_edge();
      logic nd;
      if (!rstn) begin
         m_sr = '0; m_so = 1'b0; m_busy = 1'b0; m_done = 1'b0; m_cnt = 0;
      end else begin
         nd = 1'b0;
         if (m_busy) begin
            model_op(m_mode);
            m_cnt--;
            if (m_cnt == 0) begin
               m_busy = 1'b0;
               nd = 1'b1;
            end
         end else if (burst_i) begin
            if (mode_i inside {3'd1, 3'd2, 3'd3, 3'd4, 3'd6}) begin
               m_mode = mode_i;
               m_cnt  = (burst_len_i > 4'd8) ? 8 : int'(burst_len_i);
               if (m_cnt == 0) nd = 1'b1;
               else m_busy = 1'b1;
            end
         end else if (en_i) begin
            model_op(mode_i);
         end
         m_done = nd;
      end
   endtask

   // one clock: predict, push, clock, pop and compare
   task automatic cyc();
      exp_t e;
      model_edge();
      exp_q.push_back('{sr: m_sr, so: m_so, busy: m_busy, done: m_done});
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
         chk("sb_empty", 32'd1, 32'd0);
      end else begin
         e = exp_q.pop_front();
         chk("sr", 32'(sr_o), 32'(e.sr));
         chk("so", 32'(so_o), 32'(e.so));
         chk("busy", 32'(busy_o), 32'(e.busy));
         chk("done", 32'(done_o), 32'(e.done));
      end
   endtask

   task automatic idle_in();
      en_i = 1'b0; burst_i = 1'b0; mode_i = 3'd0; x_i = 1'b0;
   endtask

   task automatic do_load(input logic [W-1:0] v);
      en_i = 1'b1; burst_i = 1'b0; mode_i = 3'd5; load_i = v;
      cyc();
      idle_in();
   endtask

   task automatic do_op(input logic [2:0] md, input logic x);
      en_i = 1'b1; burst_i = 1'b0; mode_i = md; x_i = x;
      cyc();
      idle_in();
   endtask

   task automatic start_burst(input logic [2:0] md, input logic [3:0] len);
      en_i = 1'b0; burst_i = 1'b1; mode_i = md; burst_len_i = len;
      cyc();
      idle_in();
   endtask

   initial begin
      rstn = 1'b0; load_i = '0; burst_len_i = '0;
      idle_in();
      cyc();
      rstn = 1'b1;

      // 1: reset after arbitrary state
      do_load(8'h5C);
      do_op(3'd1, 1'b1);
      rstn = 1'b0;
      cyc();
      rstn = 1'b1;
      chk("rst_sr", 32'(sr_o), 32'h00);
      chk("rst_so", 32'(so_o), 32'h0);
      do_load(8'h3C);
      rstn = 1'b0;
      #3;
      rstn = 1'b1;
      #1;
      chk("rst_noedge", 32'(sr_o), 32'h3C);

      // 2: shifts
      do_load(8'hA5);
      do_op(3'd1, 1'b1);
      chk("shl", 32'(sr_o), 32'h4B);
      chk("shl_so", 32'(so_o), 32'h1);
      do_load(8'hA5);
      do_op(3'd2, 1'b0);
      chk("shr", 32'(sr_o), 32'h52);
      chk("shr_so", 32'(so_o), 32'h1);

      // 3: asr, ror, hold
      do_load(8'h80);
      do_op(3'd6, 1'b0);
      chk("asr", 32'(sr_o), 32'hC0);
      do_load(8'h01);
      do_op(3'd4, 1'b0);
      chk("ror", 32'(sr_o), 32'h80);
      chk("ror_so", 32'(so_o), 32'h1);
      do_op(3'd0, 1'b1);
      do_op(3'd7, 1'b1);
      chk("hold", 32'(sr_o), 32'h80);

      // 4: burst rol len 3 with ignored pulses while busy
      do_load(8'h81);
      start_burst(3'd3, 4'd3);
      chk("b_busy0", 32'(busy_o), 32'h1);
      en_i = 1'b1; mode_i = 3'd5; load_i = 8'hFF;
      cyc();
      chk("b_s1", 32'(sr_o), 32'h03);
      burst_i = 1'b1; burst_len_i = 4'd5;
      cyc();
      chk("b_s2", 32'(sr_o), 32'h06);
      idle_in();
      cyc();
      chk("b_done_sr", 32'(sr_o), 32'h0C);
      chk("b_done", 32'(done_o), 32'h1);
      cyc();
      chk("b_done_clr", 32'(done_o), 32'h0);

      // 5: zero length, saturated length, burst with load mode
      start_burst(3'd1, 4'd0);
      chk("len0_done", 32'(done_o), 32'h1);
      chk("len0_sr", 32'(sr_o), 32'h0C);
      do_load(8'h5A);
      start_burst(3'd3, 4'd12);
      repeat (8) cyc();
      chk("len12_sr", 32'(sr_o), 32'h5A);
      chk("len12_done", 32'(done_o), 32'h1);
      load_i = 8'h11;
      start_burst(3'd5, 4'd4);
      chk("bload_ign", 32'(sr_o), 32'h5A);
      cyc();

      // 6: reset aborts a burst
      do_load(8'h00);
      start_burst(3'd1, 4'd8);
      x_i = 1'b1;
      repeat (3) cyc();
      chk("abort_pre", 32'(sr_o), 32'h07);
      rstn = 1'b0;
      cyc();
      rstn = 1'b1;
      chk("abort_sr", 32'(sr_o), 32'h00);
      chk("abort_busy", 32'(busy_o), 32'h0);
      cyc();
      chk("abort_nodone", 32'(done_o), 32'h0);

      // random traffic
      for (int i = 0; i < 400; i++) begin
         rstn        = ($urandom_range(0, 49) != 0);
         mode_i      = 3'($urandom_range(0, 7));
         en_i        = 1'($urandom_range(0, 1));
         burst_i     = ($urandom_range(0, 5) == 0);
         burst_len_i = 4'($urandom_range(0, 15));
         x_i         = 1'($urandom_range(0, 1));
         load_i      = 8'($urandom_range(0, 255));
         cyc();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
